// File: rtl/pipe_ctl.sv
// Pipeline sequencing controller for the 5-stage core: merges stalls, redirects,
// memory waits and halt requests into per-stage enables/flushes and perf counters.
module pipe_ctl #(
  parameter int CNT_WIDTH  = 32,
  parameter int DELAY_SLOT = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 id_stall,
  input  logic                 ex_branch_taken,
  input  logic [31:0]          ex_branch_target,
  input  logic                 imem_wait,
  input  logic                 dmem_wait,
  input  logic                 halt_req,
  input  logic                 resume,
  output logic                 pc_en,
  output logic                 if_id_en,
  output logic                 id_ex_en,
  output logic                 ex_mem_en,
  output logic                 mem_wb_en,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic                 ex_mem_flush,
  output logic                 pc_sel,
  output logic [31:0]          pc_target,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  localparam logic                 DS      = (DELAY_SLOT != 0);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_e;

  state_e               state_q, state_d;
  logic                 v_id_q, v_ex_q, v_mem_q, v_wb_q;
  logic                 v_id_d, v_ex_d, v_mem_d, v_wb_d;
  logic                 redir_pend_q, redir_pend_d;
  logic [31:0]          target_q, target_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
  logic                 stall_inc, flush_inc, defer;

  always_comb begin
    state_d      = state_q;
    redir_pend_d = redir_pend_q;
    target_d     = target_q;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    pc_sel       = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    pc_target    = redir_pend_q ? target_q : ex_branch_target;
    // With an architected delay slot a load-use stall holds the slot in ID,
    // so the redirect has to wait until the stall clears.
    defer        = DS & id_stall;

    if (state_q == HALTED || dmem_wait) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
      stall_inc = (state_q != HALTED);
    end else if ((ex_branch_taken || redir_pend_q) && !defer) begin
      pc_sel       = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_flush  = ~DS;
      flush_inc    = 1'b1;
      redir_pend_d = 1'b0;
    end else if (id_stall) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
      stall_inc   = 1'b1;
      if (ex_branch_taken) begin
        redir_pend_d = 1'b1;
        target_d     = ex_branch_target;
      end
    end else if (imem_wait) begin
      pc_en       = 1'b0;
      if_id_flush = 1'b1;
      stall_inc   = 1'b1;
    end

    // Draining stops fetch; only a redirect may still move the PC.
    if (state_q == DRAIN && !pc_sel) begin
      pc_en       = 1'b0;
      if_id_flush = if_id_en;
    end

    v_id_d  = if_id_en  ? ~if_id_flush             : v_id_q;
    v_ex_d  = id_ex_en  ? (v_id_q  & ~id_ex_flush)  : v_ex_q;
    v_mem_d = ex_mem_en ? (v_ex_q  & ~ex_mem_flush) : v_mem_q;
    v_wb_d  = mem_wb_en ? v_mem_q                   : v_wb_q;

    case (state_q)
      RUN:     if (halt_req && !dmem_wait) state_d = DRAIN;
      DRAIN: begin
        if (!halt_req)
          state_d = RUN;
        else if (!(v_id_d | v_ex_d | v_mem_d | v_wb_d) && !redir_pend_d)
          state_d = HALTED;
      end
      HALTED:  if (resume && !halt_req) state_d = RUN;
      default: state_d = RUN;
    endcase

    stall_cnt_d = (stall_inc && stall_cnt_q != CNT_MAX) ? stall_cnt_q + CNT_ONE : stall_cnt_q;
    flush_cnt_d = (flush_inc && flush_cnt_q != CNT_MAX) ? flush_cnt_q + CNT_ONE : flush_cnt_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= RUN;
      v_id_q       <= 1'b0;
      v_ex_q       <= 1'b0;
      v_mem_q      <= 1'b0;
      v_wb_q       <= 1'b0;
      redir_pend_q <= 1'b0;
      target_q     <= '0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      v_id_q       <= v_id_d;
      v_ex_q       <= v_ex_d;
      v_mem_q      <= v_mem_d;
      v_wb_q       <= v_wb_d;
      redir_pend_q <= redir_pend_d;
      target_q     <= target_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign halted    = (state_q == HALTED);
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  // A pending branch has already left EX, so EX cannot resolve another one yet.
  assert property (@(posedge clock) disable iff (reset) !(ex_branch_taken && redir_pend_q));

endmodule

// File: tb/tb_pipe_ctl.sv
// Scoreboard bench for pipe_ctl: two instances (delay slot / 32-bit counters and
// no delay slot / 4-bit counters) share stimulus and are checked against a pipeline model.
module tb_pipe_ctl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        id_stall = 1'b0, ex_branch_taken = 1'b0, imem_wait = 1'b0, dmem_wait = 1'b0;
  logic        halt_req = 1'b0, resume = 1'b0;
  logic [31:0] ex_branch_target = '0;

  logic        pc_en_a, if_id_en_a, id_ex_en_a, ex_mem_en_a, mem_wb_en_a;
  logic        if_id_flush_a, id_ex_flush_a, ex_mem_flush_a, pc_sel_a, halted_a;
  logic [31:0] pc_target_a, stall_cnt_a, flush_cnt_a;
  logic        pc_en_b, if_id_en_b, id_ex_en_b, ex_mem_en_b, mem_wb_en_b;
  logic        if_id_flush_b, id_ex_flush_b, ex_mem_flush_b, pc_sel_b, halted_b;
  logic [31:0] pc_target_b;
  logic [3:0]  stall_cnt_b, flush_cnt_b;

  always #5 clock = ~clock;

  pipe_ctl #(.CNT_WIDTH(32), .DELAY_SLOT(1)) dut_a (
    .clock(clock), .reset(reset), .id_stall(id_stall), .ex_branch_taken(ex_branch_taken),
    .ex_branch_target(ex_branch_target), .imem_wait(imem_wait), .dmem_wait(dmem_wait),
    .halt_req(halt_req), .resume(resume), .pc_en(pc_en_a), .if_id_en(if_id_en_a),
    .id_ex_en(id_ex_en_a), .ex_mem_en(ex_mem_en_a), .mem_wb_en(mem_wb_en_a),
    .if_id_flush(if_id_flush_a), .id_ex_flush(id_ex_flush_a), .ex_mem_flush(ex_mem_flush_a),
    .pc_sel(pc_sel_a), .pc_target(pc_target_a), .halted(halted_a),
    .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a));

  pipe_ctl #(.CNT_WIDTH(4), .DELAY_SLOT(0)) dut_b (
    .clock(clock), .reset(reset), .id_stall(id_stall), .ex_branch_taken(ex_branch_taken),
    .ex_branch_target(ex_branch_target), .imem_wait(imem_wait), .dmem_wait(dmem_wait),
    .halt_req(halt_req), .resume(resume), .pc_en(pc_en_b), .if_id_en(if_id_en_b),
    .id_ex_en(id_ex_en_b), .ex_mem_en(ex_mem_en_b), .mem_wb_en(mem_wb_en_b),
    .if_id_flush(if_id_flush_b), .id_ex_flush(id_ex_flush_b), .ex_mem_flush(ex_mem_flush_b),
    .pc_sel(pc_sel_b), .pc_target(pc_target_b), .halted(halted_b),
    .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b));

  typedef struct {
    bit        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    bit        if_id_flush, id_ex_flush, ex_mem_flush, pc_sel, halted;
    bit [31:0] pc_target;
    longint    stall_cnt, flush_cnt;
  } exp_t;

  localparam int A_HOLD = 0, A_FREEZE = 1, A_REDIR = 2, A_STALL_ID = 3, A_STALL_IF = 4, A_FLOW = 5;
  localparam int M_RUN = 0, M_DRAIN = 1, M_HALTED = 2;

  // Model state per instance: index 0 = dut_a, 1 = dut_b.
  bit        ds [2] = '{1'b1, 1'b0};
  int        cw [2] = '{32, 4};
  int        mode [2];
  bit        pipe [2][4];
  bit        pend [2];
  bit [31:0] ptgt [2];
  longint    sc [2], fc [2];

  exp_t q_a [$];
  exp_t q_b [$];
  exp_t ea, eb, ga, gb;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic checkOutput(input string name, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic compareSet(input string tag, input exp_t got, input exp_t exp);
    checkOutput({tag, ".pc_en"},        got.pc_en,        exp.pc_en);
    checkOutput({tag, ".if_id_en"},     got.if_id_en,     exp.if_id_en);
    checkOutput({tag, ".id_ex_en"},     got.id_ex_en,     exp.id_ex_en);
    checkOutput({tag, ".ex_mem_en"},    got.ex_mem_en,    exp.ex_mem_en);
    checkOutput({tag, ".mem_wb_en"},    got.mem_wb_en,    exp.mem_wb_en);
    checkOutput({tag, ".if_id_flush"},  got.if_id_flush,  exp.if_id_flush);
    checkOutput({tag, ".id_ex_flush"},  got.id_ex_flush,  exp.id_ex_flush);
    checkOutput({tag, ".ex_mem_flush"}, got.ex_mem_flush, exp.ex_mem_flush);
    checkOutput({tag, ".pc_sel"},       got.pc_sel,       exp.pc_sel);
    checkOutput({tag, ".halted"},       got.halted,       exp.halted);
    checkOutput({tag, ".stall_cnt"},    got.stall_cnt,    exp.stall_cnt);
    checkOutput({tag, ".flush_cnt"},    got.flush_cnt,    exp.flush_cnt);
    if (exp.pc_sel)
      checkOutput({tag, ".pc_target"},  longint'(got.pc_target), longint'(exp.pc_target));
  endtask

  function automatic void modelReset();
    for (int i = 0; i < 2; i++) begin
      mode[i] = M_RUN;
      pend[i] = 1'b0;
      ptgt[i] = '0;
      sc[i]   = 0;
      fc[i]   = 0;
      for (int s = 0; s < 4; s++) pipe[i][s] = 1'b0;
    end
  endfunction

  // One cycle of the reference: classify the cycle by priority, derive the
  // control pattern from that class, then move instructions through 4 slots.
  function automatic exp_t modelStep(input int i, input bit st, input bit br, input bit [31:0] tgt,
                                     input bit iw, input bit dw, input bit hr, input bit rs);
    exp_t   e;
    int     act;
    bit     p0, p1, p2;
    longint cmax;
    e = '{default: 0};
    cmax = (longint'(1) << cw[i]) - 1;
    e.stall_cnt = (sc[i] > cmax) ? cmax : sc[i];
    e.flush_cnt = (fc[i] > cmax) ? cmax : fc[i];
    e.halted    = (mode[i] == M_HALTED);
    e.pc_target = pend[i] ? ptgt[i] : tgt;

    if (mode[i] == M_HALTED)                 act = A_HOLD;
    else if (dw)                             act = A_FREEZE;
    else if ((br || pend[i]) && !(ds[i] && st)) act = A_REDIR;
    else if (st)                             act = A_STALL_ID;
    else if (iw)                             act = A_STALL_IF;
    else                                     act = A_FLOW;

    if (act != A_HOLD && act != A_FREEZE) begin
      e.pc_en = 1; e.if_id_en = 1; e.id_ex_en = 1; e.ex_mem_en = 1; e.mem_wb_en = 1;
    end
    case (act)
      A_REDIR:    begin e.pc_sel = 1; e.if_id_flush = 1; e.id_ex_flush = !ds[i]; end
      A_STALL_ID: begin e.pc_en = 0; e.if_id_en = 0; e.id_ex_flush = 1; end
      A_STALL_IF: begin e.pc_en = 0; e.if_id_flush = 1; end
      default: ;
    endcase
    if (mode[i] == M_DRAIN && act != A_REDIR) begin
      e.pc_en = 0;
      if (act == A_STALL_IF || act == A_FLOW) e.if_id_flush = 1;
    end

    if (act == A_FREEZE || act == A_STALL_ID || act == A_STALL_IF) sc[i]++;
    if (act == A_REDIR) fc[i]++;

    p0 = pipe[i][0]; p1 = pipe[i][1]; p2 = pipe[i][2];
    case (act)
      A_REDIR:    begin pipe[i][3] = p2; pipe[i][2] = p1; pipe[i][1] = ds[i] ? p0 : 1'b0; pipe[i][0] = 0; end
      A_STALL_ID: begin pipe[i][3] = p2; pipe[i][2] = p1; pipe[i][1] = 0; end
      A_STALL_IF: begin pipe[i][3] = p2; pipe[i][2] = p1; pipe[i][1] = p0; pipe[i][0] = 0; end
      A_FLOW:     begin pipe[i][3] = p2; pipe[i][2] = p1; pipe[i][1] = p0; pipe[i][0] = (mode[i] == M_RUN); end
      default: ;
    endcase
    if (act == A_REDIR) pend[i] = 0;
    if (act == A_STALL_ID && br && ds[i]) begin
      pend[i] = 1;
      ptgt[i] = tgt;
    end

    case (mode[i])
      M_RUN:   if (hr && !dw) mode[i] = M_DRAIN;
      M_DRAIN: if (!hr) mode[i] = M_RUN;
               else if (!(pipe[i][0] | pipe[i][1] | pipe[i][2] | pipe[i][3]) && !pend[i]) mode[i] = M_HALTED;
      default: if (rs && !hr) mode[i] = M_RUN;
    endcase
    return e;
  endfunction

  task automatic applyStimulus(input bit rst, input bit st, input bit br, input bit [31:0] tgt,
                               input bit iw, input bit dw, input bit hr, input bit rs);
    @(posedge clock);
    #1;
    reset = rst; id_stall = st; ex_branch_taken = br; ex_branch_target = tgt;
    imem_wait = iw; dmem_wait = dw; halt_req = hr; resume = rs;
    if (rst) modelReset();
    else begin
      q_a.push_back(modelStep(0, st, br, tgt, iw, dw, hr, rs));
      q_b.push_back(modelStep(1, st, br, tgt, iw, dw, hr, rs));
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 32'h0, 0, 0, 0, 0);
  endtask

  // Monitor: outputs are combinational, so every pushed cycle is compared mid-cycle.
  always @(negedge clock) begin
    if (q_a.size() != 0 && q_b.size() != 0) begin
      ea = q_a.pop_front();
      eb = q_b.pop_front();
      ga = '{pc_en_a, if_id_en_a, id_ex_en_a, ex_mem_en_a, mem_wb_en_a, if_id_flush_a, id_ex_flush_a,
             ex_mem_flush_a, pc_sel_a, halted_a, pc_target_a, longint'(stall_cnt_a), longint'(flush_cnt_a)};
      gb = '{pc_en_b, if_id_en_b, id_ex_en_b, ex_mem_en_b, mem_wb_en_b, if_id_flush_b, id_ex_flush_b,
             ex_mem_flush_b, pc_sel_b, halted_b, pc_target_b, longint'(stall_cnt_b), longint'(flush_cnt_b)};
      compareSet("a", ga, ea);
      compareSet("b", gb, eb);
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit st, br, iw, dw, rs, rst, hr_lvl;
    bit [31:0] tgt;
    modelReset();
    $display("[TB] reset and idle flow");
    applyStimulus(1, 0, 0, 32'h0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 32'h0, 0, 0, 0, 0);
    idle(10);

    $display("[TB] single taken branch");
    applyStimulus(0, 0, 1, 32'h0000_0400, 0, 0, 0, 0);
    idle(3);

    $display("[TB] branch under load-use stall");
    applyStimulus(0, 1, 1, 32'h0000_0800, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 32'h0, 0, 0, 0, 0);
    idle(4);

    $display("[TB] branch held under dmem wait");
    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 1, 32'h0000_0C00, 0, 1, 0, 0);
    applyStimulus(0, 0, 1, 32'h0000_0C00, 0, 0, 0, 0);
    idle(2);
    applyStimulus(0, 0, 1, 32'h0000_1000, 1, 0, 0, 0);
    idle(5);

    $display("[TB] drain, halt and resume");
    for (int k = 0; k < 8; k++) applyStimulus(0, 0, 0, 32'h0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 0, 1);
    idle(3);

    $display("[TB] counter saturation");
    for (int k = 0; k < 20; k++) applyStimulus(0, 0, 0, 32'h0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 0, 0);
    @(negedge clock);
    checkOutput("sat.stall_cnt_b", longint'(stall_cnt_b), 15);

    $display("[TB] reset during drain");
    idle(4);
    applyStimulus(0, 1, 1, 32'h0000_2000, 0, 0, 1, 0);
    applyStimulus(0, 1, 0, 32'h0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 32'h0, 0, 0, 0, 0);
    idle(4);

    $display("[TB] randomized traffic");
    hr_lvl = 0;
    for (int k = 0; k < 600; k++) begin
      rst = ($urandom_range(99) == 0);
      st  = ($urandom_range(99) < 20);
      iw  = ($urandom_range(99) < 15);
      dw  = ($urandom_range(99) < 10);
      rs  = ($urandom_range(99) < 8);
      if ($urandom_range(99) < 4) hr_lvl = ~hr_lvl;
      br  = !pend[0] && mode[0] != M_HALTED && mode[1] != M_HALTED && ($urandom_range(99) < 20);
      tgt = $urandom() & 32'hFFFF_FFFC;
      applyStimulus(rst, st, br, tgt, iw, dw, hr_lvl, rs);
    end
    idle(3);
    @(negedge clock);
    @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
